alu_mdu: RTL
============

Name: alu_mdu

Overview:
- Parametrised, registered successor to the core's single-cycle ALU.
- Keeps the integer ALU op set and adds RISC-V M-extension multiply/divide, executed iteratively.
- Sits in the execute stage behind a valid/ready handshake, so the pipeline can stall on multi-cycle ops.
- Produces a result word and a zero flag for branch resolution.

Parameters:
- WIDTH, 32, operand and result width in bits; must be a power of two and ≥ 8.
- SHW, $clog2(WIDTH), derived shift-amount width; not overridable.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands and op are presented.
- in_ready  output  1  block can accept an op this cycle.
- x  input  WIDTH  operand A (dividend or multiplicand).
- y  input  WIDTH  operand B (divisor, multiplier or shift amount).
- op  input  5  operation code, alu_op_e.
- out_valid  output  1  f and zero are valid.
- out_ready  input  1  consumer takes the result this cycle.
- f  output  WIDTH  result.
- zero  output  1  high when f == 0.
- busy  output  1  high while an iterative op is in progress.

Behaviour:
- Reset: state IDLE. in_ready=1 while IDLE. out_valid=0, f=0, zero=1, busy=0. Iteration counter=0.
- Reset mid-operation aborts the op. No output is produced for it.
- Accept rule: an op is accepted on a cycle with in_valid && in_ready. in_ready = (state==IDLE).
- Op codes 0-9: ADD, SUB, AND, OR, XOR, SLL, SRL, SRA, SLT, SLTU.
  - Shifts use y[SHW-1:0] only.
  - SLT and SLTU return 0 or 1, zero-extended to WIDTH.
  - Result is registered. out_valid rises the cycle after accept (latency 1).
- Op codes 10-13: MUL, MULH, MULHSU, MULHU.
  - Implemented as a shift-add over magnitudes, with a 2·WIDTH-bit product.
  - MUL returns the low half; the others return the high half with the named signedness.
- Op codes 14-17: DIV, DIVU, REM, REMU.
  - Implemented as restoring division over magnitudes.
- Op codes 18-31: f = x, latency 1.
- FSM states:
  - IDLE: on accept of a single-cycle op or a short-circuit case, go to DONE. On accept of an iterative op, go to BUSY with counter=WIDTH.
  - BUSY: one iteration per cycle, counter decrements. When counter reaches 1, go to FIX.
  - FIX: apply sign correction (two's-complement negate where required), then go to DONE.
  - DONE: out_valid=1. On out_ready, go to IDLE.
- Iterative latency: accept at cycle N, out_valid at N+WIDTH+2. With WIDTH=32, that is N+34.
- Divide short-circuits, all latency 1, no BUSY:
  - y==0: DIV/DIVU return all-ones. REM/REMU return x.
  - Signed overflow (x = most negative, y = -1): DIV returns x, REM returns 0.
- Output hold: while out_valid && !out_ready, f and zero hold stable.
- zero is registered together with f.
- No new op is accepted until the held result is consumed. There is no accept on the same cycle as the out_ready handshake; the next accept is possible one cycle later, in IDLE.
- busy = (state==BUSY || state==FIX).
- Operands and op are captured at accept. Input changes afterwards have no effect.

Decomposition:
- Shared package alu_pkg holds:
  - typedef enum logic [4:0] alu_op_e, with the encodings above;
  - function is_iter(alu_op_e), true for iterative multiply/divide ops;
  - a localparam for the default WIDTH.
- One sub-module, mdu_iter (parameter WIDTH), owns:
  - the magnitude registers, iteration counter and partial product/remainder;
  - start/done pulses.
- alu_mdu keeps the single-cycle datapath, the short-circuit logic, the FIX stage and the handshake FSM.

Test Plan:
1. Reset, then ADD with x=5, y=7 and out_ready=1 -> out_valid one cycle after accept; f=12, zero=0; in_ready back high the following cycle.
2. SUB with x=9, y=9 -> f=0, zero=1. SRA with x=0x80000000, y=0x21 (shift by 1) -> f=0xC0000000.
3. MULH with x=0x80000000, y=0x80000000 -> f=0x40000000 at accept+34; busy high for cycles 1-33; in_ready low throughout.
4. DIV with x=-7, y=2 -> f=-3. REM on the same operands -> f=-1. DIVU with x=7, y=0 -> f=0xFFFFFFFF at latency 1. DIV with x=0x80000000, y=-1 -> f=0x80000000, latency 1.
5. DIVU started with x=100, y=3, rst asserted at iteration 10 -> all outputs at reset values the next cycle; a following ADD with x=1, y=1 -> f=2.
6. Backpressure: REMU with x=100, y=7 and out_ready held low for 5 cycles after out_valid -> f=2 and zero=0 stable throughout; in_valid asserted meanwhile is not accepted; result consumed on the out_ready cycle; that pending op accepted one cycle later.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for the execute-stage ALU/MDU: op encodings, FSM states and the
// iterative-op classifier.
package alu_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [4:0] {
    OP_ADD    = 5'd0,
    OP_SUB    = 5'd1,
    OP_AND    = 5'd2,
    OP_OR     = 5'd3,
    OP_XOR    = 5'd4,
    OP_SLL    = 5'd5,
    OP_SRL    = 5'd6,
    OP_SRA    = 5'd7,
    OP_SLT    = 5'd8,
    OP_SLTU   = 5'd9,
    OP_MUL    = 5'd10,
    OP_MULH   = 5'd11,
    OP_MULHSU = 5'd12,
    OP_MULHU  = 5'd13,
    OP_DIV    = 5'd14,
    OP_DIVU   = 5'd15,
    OP_REM    = 5'd16,
    OP_REMU   = 5'd17
  } alu_op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_FIX,
    S_DONE
  } state_e;

  function automatic logic is_iter(alu_op_e o);
    return (o >= OP_MUL) && (o <= OP_REMU);
  endfunction

endpackage

// File: rtl/mdu_iter.sv
// Iterative unsigned engine: shift-add multiply or restoring divide over
// operand magnitudes, one bit per cycle for WIDTH cycles.
module mdu_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] m_r;
  logic             div_r;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;

  // hi:lo is the product for multiply, remainder:quotient for divide
  always_comb begin
    mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, m_r} : '0);
    div_shift = {hi, lo[WIDTH-1]};
    div_diff  = div_shift - {1'b0, m_r};
  end

  assign done = (cnt == CW'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      hi    <= '0;
      lo    <= '0;
      m_r   <= '0;
      div_r <= 1'b0;
    end else if (start) begin
      cnt   <= CW'(WIDTH);
      hi    <= '0;
      div_r <= is_div;
      lo    <= is_div ? a : b;
      m_r   <= is_div ? b : a;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
      if (div_r) begin
        if (!div_diff[WIDTH]) begin
          hi <= div_diff[WIDTH-1:0];
          lo <= {lo[WIDTH-2:0], 1'b1};
        end else begin
          hi <= div_shift[WIDTH-1:0];
          lo <= {lo[WIDTH-2:0], 1'b0};
        end
      end else begin
        hi <= mul_sum[WIDTH:1];
        lo <= {mul_sum[0], lo[WIDTH-1:1]};
      end
    end
  end

endmodule

// File: rtl/alu_mdu.sv
// Registered execute-stage ALU with iterative RISC-V M multiply/divide behind a
// valid/ready handshake.
module alu_mdu
  import alu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [4:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] f,
  output logic             zero,
  output logic             busy
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_e  state, state_nx;
  alu_op_e op_in, op_r;
  logic    neg_r;

  logic             start, done, load_quick;
  logic             is_div_op, y_zero, ovf, quick;
  logic             x_sgn, y_sgn, x_neg, y_neg, neg_in;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] alu_res, quick_res, fix_res;
  logic [WIDTH-1:0] x_mag, y_mag, hi, lo, q_n, r_n;
  logic [2*WIDTH-1:0] prod_n;

  assign op_in = alu_op_e'(op);
  assign shamt = y[SHW-1:0];

  always_comb begin
    alu_res = x;
    case (op_in)
      OP_ADD:  alu_res = x + y;
      OP_SUB:  alu_res = x - y;
      OP_AND:  alu_res = x & y;
      OP_OR:   alu_res = x | y;
      OP_XOR:  alu_res = x ^ y;
      OP_SLL:  alu_res = x << shamt;
      OP_SRL:  alu_res = x >> shamt;
      OP_SRA:  alu_res = $signed(x) >>> shamt;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(x) < $signed(y))};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (x < y)};
      default: alu_res = x;
    endcase
  end

  // Divide-by-zero and signed overflow finish in one cycle without iterating
  always_comb begin
    is_div_op = op_in inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    y_zero    = (y == '0);
    ovf       = (op_in == OP_DIV || op_in == OP_REM) && (x == MIN_NEG) && (y == '1);
    quick     = !is_iter(op_in) || (is_div_op && (y_zero || ovf));
    if (is_div_op && y_zero)
      quick_res = (op_in == OP_DIV || op_in == OP_DIVU) ? '1 : x;
    else if (ovf)
      quick_res = (op_in == OP_DIV) ? x : '0;
    else
      quick_res = alu_res;
  end

  always_comb begin
    x_sgn  = op_in inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    y_sgn  = op_in inside {OP_MULH, OP_DIV, OP_REM};
    x_neg  = x_sgn & x[WIDTH-1];
    y_neg  = y_sgn & y[WIDTH-1];
    x_mag  = x_neg ? -x : x;
    y_mag  = y_neg ? -y : y;
    neg_in = (op_in == OP_REM) ? x_neg : (x_neg ^ y_neg);
  end

  mdu_iter #(.WIDTH(WIDTH)) u_mdu (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .is_div (is_div_op),
    .a      (x_mag),
    .b      (y_mag),
    .done   (done),
    .hi     (hi),
    .lo     (lo)
  );

  // High-half sign correction needs the full 2*WIDTH negate so borrows reach it
  always_comb begin
    prod_n = neg_r ? -{hi, lo} : {hi, lo};
    q_n    = neg_r ? -lo : lo;
    r_n    = neg_r ? -hi : hi;
    case (op_r)
      OP_MUL:                         fix_res = prod_n[WIDTH-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:   fix_res = prod_n[2*WIDTH-1:WIDTH];
      OP_DIV, OP_DIVU:                fix_res = q_n;
      default:                        fix_res = r_n;
    endcase
  end

  always_comb begin
    state_nx   = state;
    start      = 1'b0;
    load_quick = 1'b0;
    case (state)
      S_IDLE: begin
        if (in_valid) begin
          if (quick) begin
            load_quick = 1'b1;
            state_nx   = S_DONE;
          end else begin
            start    = 1'b1;
            state_nx = S_BUSY;
          end
        end
      end
      S_BUSY:  if (done) state_nx = S_FIX;
      S_FIX:   state_nx = S_DONE;
      S_DONE:  if (out_ready) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign busy      = (state == S_BUSY) || (state == S_FIX);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      op_r  <= OP_ADD;
      neg_r <= 1'b0;
      f     <= '0;
      zero  <= 1'b1;
    end else begin
      state <= state_nx;
      if (start) begin
        op_r  <= op_in;
        neg_r <= neg_in;
      end
      if (load_quick) begin
        f    <= quick_res;
        zero <= (quick_res == '0);
      end else if (state == S_FIX) begin
        f    <= fix_res;
        zero <= (fix_res == '0);
      end
    end
  end

endmodule
